// File: rtl/pc_fetch.sv
// Program counter and instruction fetch for the GCore datapath.
// Resolves JMP/JZ/CALL/RET/HLT locally and keeps a small return-address stack.
module pc_fetch #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              ena,
  input  logic              pc,
  input  logic              opram,
  input  logic              acc_zero,
  input  logic [15:0]       rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [3:0]        opcode,
  output logic [11:0]       operand,
  output logic              halt,
  output logic              stack_err
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [3:0] {
    OP_JMP  = 4'hA,
    OP_JZ   = 4'hB,
    OP_CALL = 4'hC,
    OP_RET  = 4'hD,
    OP_HLT  = 4'hF
  } op_e;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              first_q, first_d;
  logic              halt_q, halt_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              advance, latch, push_en;
  logic [ADDR_W-1:0] pc_inc, target;
  logic [IDX_W-1:0]  push_idx, pop_idx;

  assign advance  = ena & pc & ~halt_q;
  assign latch    = ena & opram & ~halt_q;
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign target   = instr_q[ADDR_W-1:0];
  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

  // Decode always uses the previously latched instruction, so a
  // coincident opram strobe cannot affect this frame's PC update.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    sp_d    = sp_q;
    first_d = first_q;
    halt_d  = halt_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (advance) begin
      if (first_q) begin
        first_d = 1'b0;
      end else begin
        case (instr_q[15:12])
          OP_JMP: pc_d = target;
          OP_JZ:  pc_d = acc_zero ? target : pc_inc;
          OP_CALL: begin
            if (sp_q == SP_FULL) begin
              err_d  = 1'b1;
              halt_d = 1'b1;
            end else begin
              push_en = 1'b1;
              sp_d    = sp_q + SP_W'(1);
              pc_d    = target;
            end
          end
          OP_RET: begin
            if (sp_q == '0) begin
              err_d  = 1'b1;
              halt_d = 1'b1;
            end else begin
              sp_d = sp_q - SP_W'(1);
              pc_d = stack_q[pop_idx];
            end
          end
          OP_HLT:  halt_d = 1'b1;
          default: pc_d = pc_inc;
        endcase
      end
    end
    if (latch) instr_d = rom_data;
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      sp_q    <= '0;
      first_q <= 1'b1;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      sp_q    <= sp_d;
      first_q <= first_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

  // Stack contents need no reset; sp alone defines what is valid.
  always_ff @(posedge clk_in) begin
    if (rst && push_en) stack_q[push_idx] <= pc_inc;
  end

  assign rom_addr  = pc_q;
  assign opcode    = instr_q[15:12];
  assign operand   = instr_q[11:0];
  assign halt      = halt_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a behavioural ROM plus hand-computed frame results.
module tb_pc_fetch;

  logic        clk_in = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b1;
  logic        pc = 1'b0;
  logic        opram = 1'b0;
  logic        acc_zero = 1'b0;
  logic [15:0] rom_data;
  logic [7:0]  rom_addr;
  logic [3:0]  opcode;
  logic [11:0] operand;
  logic        halt;
  logic        stack_err;

  logic [15:0] rom [256];
  int checks = 0;
  int failures = 0;

  assign rom_data = rom[rom_addr];

  pc_fetch #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
    .clk_in(clk_in), .rst(rst), .ena(ena), .pc(pc), .opram(opram),
    .acc_zero(acc_zero), .rom_data(rom_data), .rom_addr(rom_addr),
    .opcode(opcode), .operand(operand), .halt(halt), .stack_err(stack_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk_in) rst = 1'b0;
    @(negedge clk_in) rst = 1'b1;
  endtask

  // One sequencer frame: pc strobe, opram strobe, two idle phases.
  task automatic frame();
    @(negedge clk_in) pc = 1'b1;
    @(negedge clk_in) begin pc = 1'b0; opram = 1'b1; end
    @(negedge clk_in) opram = 1'b0;
    @(negedge clk_in);
  endtask

  initial begin
    rom_clear();
    rom[0] = 16'h1005;
    rom[1] = 16'h2007;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("rst_addr", rom_addr, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_operand", operand, 0);
    chk("rst_halt", halt, 0);
    chk("rst_err", stack_err, 0);
    rst = 1'b1;

    // Sequential fetch
    frame();
    chk("seq_f1_addr", rom_addr, 8'h00);
    chk("seq_f1_op", {opcode, operand}, 16'h1005);
    frame();
    chk("seq_f2_addr", rom_addr, 8'h01);
    chk("seq_f2_op", {opcode, operand}, 16'h2007);
    frame();
    chk("seq_f3_addr", rom_addr, 8'h02);

    // Simultaneous pc/opram: PC from old instr, instr from pre-update PC
    do_reset();
    frame();
    @(negedge clk_in) begin pc = 1'b1; opram = 1'b1; end
    @(negedge clk_in) begin pc = 1'b0; opram = 1'b0; end
    chk("sim_addr", rom_addr, 8'h01);
    chk("sim_op", {opcode, operand}, 16'h1005);

    // ena=0 mid-frame holds everything
    do_reset();
    frame();
    rom[0] = 16'h3333;
    ena = 1'b0;
    frame();
    chk("ena_addr", rom_addr, 8'h00);
    chk("ena_op", {opcode, operand}, 16'h1005);
    ena = 1'b1;
    frame();
    chk("ena_resume_addr", rom_addr, 8'h01);
    chk("ena_resume_op", {opcode, operand}, 16'h2007);

    // JMP
    rom_clear();
    rom[0] = 16'hA040;
    rom[8'h40] = 16'h1234;
    do_reset();
    frame();
    chk("jmp_f1_op", opcode, 4'hA);
    frame();
    chk("jmp_addr", rom_addr, 8'h40);
    chk("jmp_op", {opcode, operand}, 16'h1234);

    // JZ taken / not taken
    for (int t = 0; t < 2; t++) begin
      rom_clear();
      rom[3] = 16'hB020;
      acc_zero = (t == 0);
      do_reset();
      for (int f = 0; f < 4; f++) frame();
      chk("jz_at3", rom_addr, 8'h03);
      frame();
      chk(t == 0 ? "jz_taken" : "jz_not_taken", rom_addr, t == 0 ? 8'h20 : 8'h04);
    end
    acc_zero = 1'b0;

    // CALL/RET, then RET on an empty stack underflows
    rom_clear();
    rom[0] = 16'hC010;
    rom[1] = 16'hD000;
    rom[8'h10] = 16'hD000;
    do_reset();
    frame();
    chk("call_f1_addr", rom_addr, 8'h00);
    frame();
    chk("call_addr", rom_addr, 8'h10);
    frame();
    chk("ret_addr", rom_addr, 8'h01);
    chk("ret_err", stack_err, 0);
    frame();
    chk("under_err", stack_err, 1);
    chk("under_halt", halt, 1);
    chk("under_addr", rom_addr, 8'h01);

    // Overflow: five nested calls
    rom_clear();
    for (int i = 0; i < 5; i++) rom[i] = 16'hC000 | 16'(i + 1);
    do_reset();
    for (int f = 0; f < 5; f++) frame();
    chk("ovf_pre_addr", rom_addr, 8'h04);
    chk("ovf_pre_err", stack_err, 0);
    frame();
    chk("ovf_err", stack_err, 1);
    chk("ovf_halt", halt, 1);
    chk("ovf_addr", rom_addr, 8'h04);
    frame();
    chk("ovf_frozen", rom_addr, 8'h04);
    do_reset();
    chk("ovf_rst_addr", rom_addr, 8'h00);
    chk("ovf_rst_err", stack_err, 0);
    chk("ovf_rst_halt", halt, 0);
    chk("ovf_rst_op", {opcode, operand}, 16'h0000);

    // Return address wraps when CALL sits at 0xFF
    rom_clear();
    rom[0] = 16'hA0FF;
    rom[8'hFF] = 16'hC010;
    rom[8'h10] = 16'hD000;
    do_reset();
    frame();
    frame();
    chk("cw_ff", rom_addr, 8'hFF);
    frame();
    chk("cw_sub", rom_addr, 8'h10);
    frame();
    chk("cw_ret_wrap", rom_addr, 8'h00);

    // PC wrap via NOP at 0xFF, then HLT at 0x00
    rom_clear();
    rom[0] = 16'hA0FF;
    do_reset();
    frame();
    frame();
    chk("wrap_ff", rom_addr, 8'hFF);
    rom[0] = 16'hF000;
    frame();
    chk("wrap_00", rom_addr, 8'h00);
    chk("wrap_hlt_op", opcode, 4'hF);
    frame();
    chk("hlt_halt", halt, 1);
    chk("hlt_err", stack_err, 0);
    rom[0] = 16'h1111;
    for (int f = 0; f < 3; f++) frame();
    chk("hlt_addr_hold", rom_addr, 8'h00);
    chk("hlt_op_hold", {opcode, operand}, 16'hF000);
    chk("hlt_still", halt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
